// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse compressor and related width-measuring blocks.
package pulse_pkg;

  // Compressor FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUAL  = 2'd1,
    HIGH  = 2'd2,
    STUCK = 2'd3
  } pc_state_t;

  // Bits needed to hold a count of 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dff.sv
// Generic enabled D flip-flop bank with asynchronous active-low reset.
module dff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Capture i_d whenever enabled; clear on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sat_counter.sv
// Up-counter that saturates at MAX, with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_at_max
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == MaxVal);

  // Count up on i_inc until MaxVal, then hold; i_clr wins over i_inc.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_at_max = w_at_max;

endmodule

// File: rtl/pulse_compressor.sv
// Turns a pulse of arbitrary length into a single-cycle strobe, rejecting short glitches,
// flagging stuck-high inputs and reporting the measured width of each qualified pulse.
module pulse_compressor
  import pulse_pkg::*;
#(
  parameter int MIN_WIDTH = 2,
  parameter int MAX_WIDTH = 255,
  localparam int CNT_W    = cnt_width(MAX_WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_d,
  output logic             o_q,
  output logic             o_rejected,
  output logic             o_too_long,
  output logic             o_width_valid,
  output logic [CNT_W-1:0] o_width
);

  if (MIN_WIDTH < 1 || MIN_WIDTH >= MAX_WIDTH) begin : g_bad_params
    $error("pulse_compressor: need 1 <= MIN_WIDTH < MAX_WIDTH");
  end

  // Comparisons are done one bit wider so cnt+1 never wraps.
  localparam logic [CNT_W:0] MinCmp = (CNT_W + 1)'(MIN_WIDTH);
  localparam logic [CNT_W:0] MaxCmp = (CNT_W + 1)'(MAX_WIDTH);

  logic             w_d_r;
  logic [CNT_W-1:0] w_cnt;
  logic             w_at_max;
  logic             w_clr;
  logic             w_inc;
  logic [CNT_W:0]   w_cnt_p1;

  pc_state_t        r_state;
  logic             r_q;
  logic             r_rejected;
  logic             r_too_long;
  logic             r_width_valid;
  logic [CNT_W-1:0] r_width;

  // Single input register; its load edge is the sampling edge for d.
  dff #(
    .W (1)
  ) u_d_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (1'b1),
    .i_d     (i_d),
    .o_q     (w_d_r)
  );

  // Run length of consecutive high samples; a low sample or disable clears it.
  assign w_clr = ~i_en | ~w_d_r;
  assign w_inc = w_d_r & ~w_at_max;

  sat_counter #(
    .W   (CNT_W),
    .MAX (MAX_WIDTH)
  ) u_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_clr),
    .i_inc    (w_inc),
    .o_count  (w_cnt),
    .o_at_max (w_at_max)
  );

  assign w_cnt_p1 = {1'b0, w_cnt} + (CNT_W + 1)'(1);

  // Qualify / track / report FSM with all outputs registered; strobes default low each edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_q           <= 1'b0;
      r_rejected    <= 1'b0;
      r_too_long    <= 1'b0;
      r_width_valid <= 1'b0;
      r_width       <= '0;
    end else begin
      r_q           <= 1'b0;
      r_rejected    <= 1'b0;
      r_too_long    <= 1'b0;
      r_width_valid <= 1'b0;
      if (!i_en) begin
        // Drop any pulse in progress silently; r_width keeps the last report.
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_d_r) begin
              if (MIN_WIDTH == 1) begin
                r_state <= HIGH;
                r_q     <= 1'b1;
              end else begin
                r_state <= QUAL;
              end
            end
          end
          QUAL: begin
            if (!w_d_r) begin
              r_state    <= IDLE;
              r_rejected <= 1'b1;
            end else if (w_cnt_p1 == MinCmp) begin
              r_state <= HIGH;
              r_q     <= 1'b1;
            end
          end
          HIGH: begin
            if (!w_d_r) begin
              r_state       <= IDLE;
              r_width_valid <= 1'b1;
              r_width       <= w_cnt;
            end else if (w_cnt_p1 == MaxCmp) begin
              r_state    <= STUCK;
              r_too_long <= 1'b1;
            end
          end
          STUCK: begin
            // Counter is pinned at MAX_WIDTH here, so the report saturates too.
            if (!w_d_r) begin
              r_state       <= IDLE;
              r_width_valid <= 1'b1;
              r_width       <= w_cnt;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_q           = r_q;
  assign o_rejected    = r_rejected;
  assign o_too_long    = r_too_long;
  assign o_width_valid = r_width_valid;
  assign o_width       = r_width;

endmodule

// File: tb/tb_pulse_compressor.sv
// Directed bench for pulse_compressor with MIN_WIDTH=2, MAX_WIDTH=8.
module tb_pulse_compressor;

  localparam int MinW = 2;
  localparam int MaxW = 8;
  localparam int CntW = 4;

  logic            i_clk;
  logic            i_rst_n;
  logic            i_en;
  logic            i_d;
  logic            o_q;
  logic            o_rejected;
  logic            o_too_long;
  logic            o_width_valid;
  logic [CntW-1:0] o_width;

  pulse_compressor #(
    .MIN_WIDTH (MinW),
    .MAX_WIDTH (MaxW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .i_d           (i_d),
    .o_q           (o_q),
    .o_rejected    (o_rejected),
    .o_too_long    (o_too_long),
    .o_width_valid (o_width_valid),
    .o_width       (o_width)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Per-scenario strobe statistics, gathered one edge at a time.
  int n_q, n_rej, n_tl, n_wv;
  int edge_no, q_edge, tl_edge, w_sum;
  int last_w;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_q = 0; n_rej = 0; n_tl = 0; n_wv = 0;
    edge_no = 0; q_edge = -1; tl_edge = -1; w_sum = 0; last_w = -1;
  endtask

  // Drive d for one rising edge, then sample outputs 1 time unit after it.
  task automatic cyc(input logic dv);
    i_d = dv;
    @(posedge i_clk);
    #1;
    edge_no++;
    if (o_q) begin n_q++; q_edge = edge_no; end
    if (o_rejected) n_rej++;
    if (o_too_long) begin n_tl++; tl_edge = edge_no; end
    if (o_width_valid) begin n_wv++; last_w = int'(o_width); w_sum += int'(o_width); end
  endtask

  task automatic cycn(input logic dv, input int n);
    for (int i = 0; i < n; i++) cyc(dv);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_en    = 1'b1;
    i_d     = 1'b1;
    clear_stats();

    // Reset held with d high while the clock runs.
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_q", int'(o_q), 0);
    check_eq("rst_rejected", int'(o_rejected), 0);
    check_eq("rst_too_long", int'(o_too_long), 0);
    check_eq("rst_width_valid", int'(o_width_valid), 0);
    check_eq("rst_width", int'(o_width), 0);

    // Release with d high: edges 1,2 sample high, q appears on edge 3.
    i_rst_n = 1'b1;
    clear_stats();
    cycn(1'b1, 3);
    check_eq("rel_q_count", n_q, 1);
    check_eq("rel_q_edge", q_edge, 3);
    cycn(1'b0, 3);
    check_eq("rel_wv_count", n_wv, 1);
    check_eq("rel_width", last_w, 3);

    // Glitch: one high sample.
    clear_stats();
    cyc(1'b1);
    cycn(1'b0, 3);
    check_eq("glitch_rejected", n_rej, 1);
    check_eq("glitch_q", n_q, 0);
    check_eq("glitch_wv", n_wv, 0);
    check_eq("glitch_width_hold", int'(o_width), 3);

    // Normal pulse of 5.
    clear_stats();
    cycn(1'b1, 5);
    cycn(1'b0, 3);
    check_eq("norm_q_count", n_q, 1);
    check_eq("norm_q_edge", q_edge, 3);
    check_eq("norm_wv_count", n_wv, 1);
    check_eq("norm_width", last_w, 5);
    check_eq("norm_rej_tl", n_rej + n_tl, 0);
    cycn(1'b0, 2);
    check_eq("norm_width_hold", int'(o_width), 5);

    // Stuck-high pulse of 12; counter reaches 8 on edge 9.
    clear_stats();
    cycn(1'b1, 12);
    cycn(1'b0, 3);
    check_eq("stuck_q_count", n_q, 1);
    check_eq("stuck_tl_count", n_tl, 1);
    check_eq("stuck_tl_edge", tl_edge, 9);
    check_eq("stuck_wv_count", n_wv, 1);
    check_eq("stuck_width", last_w, MaxW);

    // Back-to-back pulses separated by a single low sample.
    clear_stats();
    cycn(1'b1, 3);
    cyc(1'b0);
    cycn(1'b1, 3);
    cycn(1'b0, 3);
    check_eq("b2b_q_count", n_q, 2);
    check_eq("b2b_wv_count", n_wv, 2);
    check_eq("b2b_width_sum", w_sum, 6);
    check_eq("b2b_width_last", last_w, 3);
    check_eq("b2b_rejected", n_rej, 0);

    // Asynchronous reset mid-pulse (counter at 4), between clock edges.
    clear_stats();
    cycn(1'b1, 5);
    check_eq("arst_pre_width", int'(o_width), 3);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("arst_width_cleared", int'(o_width), 0);
    check_eq("arst_strobes", int'({o_q, o_rejected, o_too_long, o_width_valid}), 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    clear_stats();
    cycn(1'b1, 3);
    check_eq("arst_new_q_edge", q_edge, 3);
    cycn(1'b0, 3);
    check_eq("arst_new_wv", n_wv, 1);
    check_eq("arst_new_width", last_w, 3);

    // Enable drop mid-pulse: establish width 6, then drop a pulse at count 4.
    clear_stats();
    cycn(1'b1, 6);
    cycn(1'b0, 3);
    check_eq("en_pre_width", last_w, 6);
    clear_stats();
    cycn(1'b1, 5);
    i_en = 1'b0;
    cycn(1'b1, 2);
    check_eq("en_drop_wv", n_wv, 0);
    check_eq("en_drop_rej", n_rej, 0);
    check_eq("en_drop_width_hold", int'(o_width), 6);
    check_eq("en_drop_q_low", int'(o_q), 0);
    // Re-enable with d_r already high: fresh count, q on the second edge.
    i_en = 1'b1;
    clear_stats();
    cycn(1'b1, 3);
    cycn(1'b0, 3);
    check_eq("en_new_q_edge", q_edge, 2);
    check_eq("en_new_wv", n_wv, 1);
    check_eq("en_new_width", last_w, 4);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
